// File: rtl/midi_stream_parser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | midi_stream_parser: MIDI channel-voice parser with running status,       |
// | channel-mask filtering and an output message FIFO (valid/ready).         |
// | Optional macro MIDI_NOTE_ON_ZERO_AS_OFF_EN: note-on velocity 0 -> type 8.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module midi_stream_parser #(
    parameter int                            DATA_WIDTH    = 7,
    parameter int                            CHANNEL_WIDTH = 4,
    parameter logic [2**CHANNEL_WIDTH-1:0]   CHANNEL_MASK  = 16'hFFFF,
    parameter int                            FIFO_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             byte_valid,
    input  logic [7:0]                       byte_data,
    output logic                             msg_valid,
    input  logic                             msg_ready,
    output logic [3:0]                       msg_type,
    output logic [CHANNEL_WIDTH-1:0]         msg_channel,
    output logic [DATA_WIDTH-1:0]            msg_data1,
    output logic [DATA_WIDTH-1:0]            msg_data2,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
    output logic                             overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 4 + CHANNEL_WIDTH + 2 * DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_D1 = 2'd1,
        ST_WAIT_D2 = 2'd2
    } state_t;

    state_t                   state_q;
    logic [3:0]               type_q;
    logic [CHANNEL_WIDTH-1:0] chan_q;
    logic [DATA_WIDTH-1:0]    d1_q;

    logic [EW-1:0]            mem_q [FIFO_DEPTH];
    logic [AW-1:0]            wr_q;
    logic [AW-1:0]            rd_q;
    logic [CW-1:0]            count_q;
    logic [CW-1:0]            count_d;
    logic                     overflow_q;

    logic [DATA_WIDTH-1:0]    data_in;
    logic                     cmp_valid;
    logic [3:0]               cmp_type;
    logic [DATA_WIDTH-1:0]    cmp_d1;
    logic [DATA_WIDTH-1:0]    cmp_d2;
    logic                     accept;
    logic                     full;
    logic                     pop;
    logic                     push;
    logic                     drop;

    assign data_in = DATA_WIDTH'(byte_data[6:0]);

    // Single-byte types (C, D) complete on their first data byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            type_q  <= '0;
            chan_q  <= '0;
            d1_q    <= '0;
        end else if (byte_valid) begin
            if (byte_data >= 8'hF8) begin
                state_q <= state_q;
            end else if (byte_data >= 8'hF0) begin
                state_q <= ST_IDLE;
                type_q  <= '0;
                chan_q  <= '0;
            end else if (byte_data[7]) begin
                type_q  <= byte_data[7:4];
                chan_q  <= CHANNEL_WIDTH'(byte_data[3:0]);
                state_q <= ST_WAIT_D1;
            end else begin
                case (state_q)
                    ST_WAIT_D1: begin
                        d1_q <= data_in;
                        if (type_q != 4'hC && type_q != 4'hD) begin
                            state_q <= ST_WAIT_D2;
                        end
                    end
                    ST_WAIT_D2: state_q <= ST_WAIT_D1;
                    default:    state_q <= state_q;
                endcase
            end
        end
    end

    always_comb begin
        cmp_valid = 1'b0;
        cmp_type  = type_q;
        cmp_d1    = d1_q;
        cmp_d2    = '0;
        if (byte_valid && !byte_data[7]) begin
            if (state_q == ST_WAIT_D1 && (type_q == 4'hC || type_q == 4'hD)) begin
                cmp_valid = 1'b1;
                cmp_d1    = data_in;
            end else if (state_q == ST_WAIT_D2) begin
                cmp_valid = 1'b1;
                cmp_d2    = data_in;
            end
        end
`ifdef MIDI_NOTE_ON_ZERO_AS_OFF_EN
        if (cmp_type == 4'h9 && cmp_d2 == '0) begin
            cmp_type = 4'h8;
        end
`endif
    end

    assign accept = cmp_valid && CHANNEL_MASK[chan_q];
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign pop    = (count_q != '0) && msg_ready;
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q       <= '0;
            rd_q       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {cmp_type, chan_q, cmp_d1, cmp_d2};
                wr_q        <= wr_q + AW'(1);
            end
            if (pop) begin
                rd_q <= rd_q + AW'(1);
            end
            count_q    <= count_d;
            overflow_q <= drop;
        end
    end

    assign {msg_type, msg_channel, msg_data1, msg_data2} = mem_q[rd_q];
    assign msg_valid  = (count_q != '0);
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
